// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// register word indices and the source index map of the microcontroller.
package irq_pkg;

  // Handshake state; the numeric values are also what STATUS[9:8] reports.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_e;

  // Register word indices on bus_addr.
  localparam logic [1:0] REG_PENDING  = 2'd0;
  localparam logic [1:0] REG_ENABLE   = 2'd1;
  localparam logic [1:0] REG_EDGE_SEL = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  // Interrupt source wiring on irq_src.
  localparam int IRQ_EXT1    = 0;
  localparam int IRQ_EXT2    = 1;
  localparam int IRQ_TIM1    = 2;
  localparam int IRQ_TIM2    = 3;
  localparam int IRQ_UART_RX = 4;
  localparam int IRQ_UART_TX = 5;
  localparam int IRQ_GPIO    = 6;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational fixed-priority encoder: the lowest set bit of req wins.
module irq_priority_enc #(
  parameter int NUM_SOURCES = 8,
  parameter int ID_W        = 5
) (
  input  logic [NUM_SOURCES-1:0] req,
  output logic [ID_W-1:0]        idx,
  output logic                   valid
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches/masks sources, picks the
// lowest-index candidate and runs a request/ack/done handshake with the core.
// Optional build macro IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer per source.
//
// Handshake: irq_out rises with a latched irq_id (REQ); a one-cycle irq_ack
// while in REQ moves to ACTIVE and drops irq_out; a one-cycle irq_done while
// ACTIVE returns to IDLE. Strobes outside those states are ignored. irq_id
// returns to 0 whenever the FSM goes back to IDLE.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int ID_W        = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic [1:0]             bus_addr,
  input  logic [31:0]            bus_wdata,
  input  logic                   bus_we,
  input  logic                   bus_re,
  output logic [31:0]            bus_rdata,
  output logic                   irq_out,
  output logic [ID_W-1:0]        irq_id,
  input  logic                   irq_ack,
  input  logic                   irq_done
);

  logic [NUM_SOURCES-1:0] src_s, src_q, pending, enable, edge_sel;
  logic [NUM_SOURCES-1:0] cand, id_mask, rise, w1c, ack_clr, sel_chg, pend_nxt;
  logic [NUM_SOURCES-1:0] wdata_n;
  logic [ID_W-1:0]        sel;
  logic                   sel_valid;
  logic [4:0]             id5;
  logic [31:0]            status;
  irq_state_e             state;
  logic                   unused_wdata;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SOURCES-1:0] sync1, sync2;

  // Two-flop synchronizer for asynchronous sources.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = irq_src;
`endif

  assign wdata_n      = bus_wdata[NUM_SOURCES-1:0];
  assign unused_wdata = ^bus_wdata;

  assign cand    = pending & enable;
  assign id_mask = NUM_SOURCES'(1) << irq_id;
  assign rise    = src_s & ~src_q;
  assign w1c     = (bus_we && bus_addr == REG_PENDING) ? wdata_n : '0;
  assign ack_clr = (state == REQ && irq_ack) ? id_mask : '0;
  // Switching a bit's mode discards whatever it had latched.
  assign sel_chg = (bus_we && bus_addr == REG_EDGE_SEL) ? (wdata_n ^ edge_sel) : '0;

  // Edge bits: a new edge beats any clear; level bits track last cycle's source.
  assign pend_nxt = ((edge_sel & (rise | (pending & ~(w1c | ack_clr))))
                    | (~edge_sel & src_s)) & ~sel_chg;

  assign id5    = 5'(irq_id);
  assign status = {22'b0, state, 3'b0, id5};

  irq_priority_enc #(
    .NUM_SOURCES(NUM_SOURCES),
    .ID_W       (ID_W)
  ) u_enc (
    .req  (cand),
    .idx  (sel),
    .valid(sel_valid)
  );

  // Source history and pending latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= src_s;
      pending <= pend_nxt;
    end
  end

  // Configuration registers and registered read port (reads see pre-write values).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable    <= '0;
      edge_sel  <= '0;
      bus_rdata <= '0;
    end else begin
      if (bus_we && bus_addr == REG_ENABLE)   enable   <= wdata_n;
      if (bus_we && bus_addr == REG_EDGE_SEL) edge_sel <= wdata_n;
      if (bus_re) begin
        case (bus_addr)
          REG_PENDING:  bus_rdata <= 32'(pending);
          REG_ENABLE:   bus_rdata <= 32'(enable);
          REG_EDGE_SEL: bus_rdata <= 32'(edge_sel);
          default:      bus_rdata <= status;
        endcase
      end
    end
  end

  // Request/acknowledge/complete handshake with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state   <= REQ;
            irq_out <= 1'b1;
            irq_id  <= sel;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= ACTIVE;
            irq_out <= 1'b0;
          end else if (~|(cand & id_mask)) begin
            state   <= IDLE;
            irq_out <= 1'b0;
            irq_id  <= '0;
          end
        end
        ACTIVE: begin
          if (irq_done) begin
            state  <= IDLE;
            irq_id <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          irq_out <= 1'b0;
          irq_id  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the controller's rules.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int N    = 8;
  localparam int ID_W = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    irq_src = '0;
  logic [1:0]      bus_addr = '0;
  logic [31:0]     bus_wdata = '0;
  logic            bus_we = 1'b0;
  logic            bus_re = 1'b0;
  logic [31:0]     bus_rdata;
  logic            irq_out;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack = 1'b0;
  logic            irq_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  irq_controller #(.NUM_SOURCES(N), .ID_W(ID_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_rdata(bus_rdata),
    .irq_out  (irq_out),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .irq_done (irq_done)
  );

  // ---------------- behavioural model ----------------
  // state: 0 idle, 1 requesting, 2 in handler
  bit          m_pend[N], m_en[N], m_edge[N], m_srcq[N];
  int          m_state, m_id;
  bit          m_out;
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_srcq[i] = 0;
    end
    m_state = 0; m_id = 0; m_out = 0; m_rdata = '0;
  endtask

  function automatic logic [31:0] pack_bits(input bit b[N]);
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) if (b[i]) v = v + (32'd1 << i);
    return v;
  endfunction

  function automatic logic [31:0] reg_value(input logic [1:0] a);
    case (a)
      2'd0:    return pack_bits(m_pend);
      2'd1:    return pack_bits(m_en);
      2'd2:    return pack_bits(m_edge);
      default: return 32'(m_state * 256 + m_id);
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: predict from the current inputs, then compare.
  task automatic step();
    bit          n_pend[N], n_en[N], n_edge[N];
    int          n_state, n_id, sel;
    bit          n_out;
    logic [31:0] n_rdata;
    logic [N-1:0] src_now;
    bit          clr;
    src_now = irq_src;
    n_rdata = m_rdata;
    if (bus_re) n_rdata = reg_value(bus_addr);
    sel = -1;
    for (int i = 0; i < N; i++) if (sel < 0 && m_pend[i] && m_en[i]) sel = i;
    for (int i = 0; i < N; i++) begin
      n_en[i]   = m_en[i];
      n_edge[i] = m_edge[i];
      if (bus_we && bus_addr == REG_ENABLE)   n_en[i]   = bus_wdata[i];
      if (bus_we && bus_addr == REG_EDGE_SEL) n_edge[i] = bus_wdata[i];
      clr = (bus_we && bus_addr == REG_PENDING && bus_wdata[i])
            || (m_state == 1 && irq_ack && m_id == i);
      if (n_edge[i] != m_edge[i])          n_pend[i] = 0;
      else if (!m_edge[i])                 n_pend[i] = src_now[i];
      else if (src_now[i] && !m_srcq[i])   n_pend[i] = 1;
      else if (clr)                        n_pend[i] = 0;
      else                                 n_pend[i] = m_pend[i];
    end
    n_state = m_state; n_id = m_id; n_out = m_out;
    case (m_state)
      0: if (sel >= 0) begin n_state = 1; n_id = sel; n_out = 1; end
      1: begin
        if (irq_ack) begin n_state = 2; n_out = 0; end
        else if (!(m_pend[m_id] && m_en[m_id])) begin n_state = 0; n_id = 0; n_out = 0; end
      end
      default: if (irq_done) begin n_state = 0; n_id = 0; end
    endcase
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = n_pend[i]; m_en[i] = n_en[i]; m_edge[i] = n_edge[i]; m_srcq[i] = src_now[i];
    end
    m_state = n_state; m_id = n_id; m_out = n_out; m_rdata = n_rdata;
    check("irq_out", 32'(irq_out), 32'(m_out));
    check("irq_id", 32'(irq_id), 32'(m_id));
    check("bus_rdata", bus_rdata, m_rdata);
  endtask

  // ---------------- driver tasks ----------------
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    step();
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus_addr = a; bus_re = 1'b1;
    step();
    bus_re = 1'b0;
    check(name, bus_rdata, exp);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1; step(); irq_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    check("reset_irq_out", 32'(irq_out), 32'd0);
    check("reset_irq_id", 32'(irq_id), 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);
    bus_read(REG_STATUS, 32'h0, "reset_status");
    bus_read(REG_PENDING, 32'h0, "reset_pending");

    // Edge mode, single source
    bus_write(REG_ENABLE, 32'h01);
    bus_write(REG_EDGE_SEL, 32'h01);
    irq_src[IRQ_EXT1] = 1'b1;
    step();
    check("edge_latency_out0", 32'(irq_out), 32'd0);
    irq_src[IRQ_EXT1] = 1'b0;
    step();
    check("edge_out", 32'(irq_out), 32'd1);
    check("edge_id", 32'(irq_id), 32'd0);
    steps(2);
    irq_ack = 1'b1; bus_addr = REG_STATUS; bus_re = 1'b1;
    step();
    irq_ack = 1'b0; bus_re = 1'b0;
    check("ack_status_pre", bus_rdata, 32'h100);
    check("ack_out", 32'(irq_out), 32'd0);
    bus_read(REG_STATUS, 32'h200, "active_status");
    bus_read(REG_PENDING, 32'h0, "ack_pending");
    pulse_done();
    bus_read(REG_STATUS, 32'h000, "done_status");

    // Fixed priority
    bus_write(REG_ENABLE, 32'hFF);
    bus_write(REG_EDGE_SEL, 32'hFF);
    irq_src[IRQ_UART_TX] = 1'b1; irq_src[IRQ_TIM1] = 1'b1;
    steps(2);
    check("prio_first_id", 32'(irq_id), 32'd2);
    pulse_ack();
    pulse_done();
    check("prio_gap_out", 32'(irq_out), 32'd0);
    step();
    check("prio_second_out", 32'(irq_out), 32'd1);
    check("prio_second_id", 32'(irq_id), 32'd5);
    pulse_ack();
    pulse_done();
    irq_src = '0;
    step();

    // Level withdraw
    bus_write(REG_EDGE_SEL, 32'h00);
    bus_write(REG_ENABLE, 32'h08);
    irq_src[IRQ_TIM2] = 1'b1;
    steps(2);
    check("level_req_id", 32'(irq_id), 32'd3);
    irq_src[IRQ_TIM2] = 1'b0;
    step();
    check("level_still_req", 32'(irq_out), 32'd1);
    step();
    check("level_withdrawn", 32'(irq_out), 32'd0);
    bus_read(REG_STATUS, 32'h0, "withdraw_status");
    bus_read(REG_PENDING, 32'h0, "withdraw_pending");

    // Masking and W1C
    bus_write(REG_ENABLE, 32'h00);
    bus_write(REG_EDGE_SEL, 32'h10);
    irq_src[IRQ_UART_RX] = 1'b1; step();
    irq_src[IRQ_UART_RX] = 1'b0; step();
    bus_read(REG_PENDING, 32'h10, "masked_pending");
    check("masked_out", 32'(irq_out), 32'd0);
    bus_write(REG_PENDING, 32'h10);
    bus_read(REG_PENDING, 32'h00, "w1c_pending");
    irq_src[IRQ_UART_RX] = 1'b1; step();
    irq_src[IRQ_UART_RX] = 1'b0;
    bus_write(REG_ENABLE, 32'h10);
    step();
    check("unmask_out", 32'(irq_out), 32'd1);
    check("unmask_id", 32'(irq_id), 32'd4);
    pulse_ack();
    pulse_done();

    // Set/clear collision
    bus_write(REG_ENABLE, 32'h00);
    bus_write(REG_EDGE_SEL, 32'h12);
    irq_src[IRQ_EXT2] = 1'b1;
    bus_write(REG_PENDING, 32'h02);
    bus_read(REG_PENDING, 32'h02, "collision_pending");
    irq_src[IRQ_EXT2] = 1'b0;

    // Reset while ACTIVE
    bus_write(REG_ENABLE, 32'h02);
    steps(2);
    check("pre_reset_id", 32'(irq_id), 32'd1);
    pulse_ack();
    bus_read(REG_ENABLE, 32'h02, "pre_reset_rdata");
    #2 reset = 1'b0;
    #1;
    check("async_irq_out", 32'(irq_out), 32'd0);
    check("async_rdata", bus_rdata, 32'd0);
    check("async_irq_id", 32'(irq_id), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    bus_read(REG_STATUS, 32'h0, "post_reset_status");
    bus_write(REG_ENABLE, 32'h01);
    bus_write(REG_EDGE_SEL, 32'h01);
    irq_src[IRQ_EXT1] = 1'b1; step();
    irq_src[IRQ_EXT1] = 1'b0; step();
    check("post_reset_out", 32'(irq_out), 32'd1);
    check("post_reset_id", 32'(irq_id), 32'd0);
    pulse_ack();
    pulse_done();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
      case ($urandom_range(0, 7))
        0: begin bus_we = 1'b1; bus_addr = 2'($urandom_range(0, 3)); bus_wdata = $urandom; end
        1: begin bus_re = 1'b1; bus_addr = 2'($urandom_range(0, 3)); end
        2: begin
          bus_we = 1'b1; bus_re = 1'b1;
          bus_addr = 2'($urandom_range(0, 3)); bus_wdata = $urandom;
        end
        default: ;
      endcase
      irq_ack  = ($urandom_range(0, 3) == 0);
      irq_done = ($urandom_range(0, 3) == 0);
      step();
      bus_we = 1'b0; bus_re = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
